// File: rtl/sar_search_4.sv
// Successive-approximation search engine driving an external comparator.
// Binary-searches the hidden target from the comparator's eq/gt/st flags.
module sar_search_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             eq,
    input  logic             gt,
    input  logic             st,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic [IW-1:0]    idx_m1;
    logic             one_hot;

    assign idx_m1  = idx_q - 1'b1;
    assign one_hot = (eq & ~gt & ~st) | (~eq & gt & ~st) | (~eq & ~gt & st);

    // Next-state: launch on start, refine one bit per compare, then report.
    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    guess_d            = '0;
                    guess_d[WIDTH-1]   = 1'b1;
                    idx_d              = IW'(WIDTH - 1);
                    found_d            = 1'b0;
                    err_d              = 1'b0;
                    state_d            = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!one_hot) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (eq) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (idx_q != '0) begin
                    if (st) begin
                        guess_d[idx_q] = 1'b0;
                    end
                    guess_d[idx_m1] = 1'b1;
                    idx_d           = idx_m1;
                end else if (st) begin
                    // Only candidate left is the guess with bit 0 cleared.
                    result_d    = guess_q;
                    result_d[0] = 1'b0;
                    found_d     = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;
    assign busy   = (state_q == S_SEARCH);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_sar_search_4.sv
// Scoreboard bench for sar_search_4 closing the loop through a comparator model.
// Expected guess sequences come from an arithmetic binary-search reference.
module tb_sar_search_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       eq, gt, st;
    logic [3:0] guess;
    logic       busy, done, found, err;
    logic [3:0] result;

    logic [3:0] target;
    int         fault;
    int         cmp_n;
    int         cyc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         exp_found;
        bit         exp_err;
        logic [3:0] exp_result;
        int         exp_len;
        bit         chk_seq;
        int         seq[$];
        int         start_cyc;
    } item_t;

    item_t sb[$];
    int    obs[$];

    sar_search_4 #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .eq(eq), .gt(gt), .st(st),
        .guess(guess), .busy(busy), .done(done),
        .found(found), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) cmp_n <= busy ? cmp_n + 1 : 0;

    // Comparator model with optional fault injection.
    always_comb begin
        eq = (guess == target);
        gt = (target > guess);
        st = (target < guess);
        if (fault == 1 && cmp_n == 1) begin
            eq = 1'b1; gt = 1'b1; st = 1'b0;
        end
        if (fault == 2) begin
            eq = 1'b0; gt = 1'b1; st = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: halving-step binary search over 0..15; t=16 means "always greater".
    function automatic void ref_seq(input int t, output int q[$]);
        int g, step;
        q = {};
        g = 8;
        step = 4;
        forever begin
            q.push_back(g);
            if (g == t || step == 0) break;
            g = (t > g) ? g + step : g - step;
            step = step / 2;
        end
    endfunction

    // Monitor: collect guesses while searching, score on every done pulse.
    always @(negedge clk) begin
        item_t it;
        bit    same;
        if (busy) obs.push_back(int'(guess));
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                it = sb.pop_front();
                check("found", int'(found), int'(it.exp_found));
                check("err", int'(err), int'(it.exp_err));
                if (it.exp_found) check("result", int'(result), int'(it.exp_result));
                check("compares", obs.size(), it.exp_len);
                check("latency", cyc - it.start_cyc, it.exp_len + 1);
                if (it.chk_seq) begin
                    same = (obs.size() == it.seq.size());
                    if (same)
                        foreach (obs[i]) if (obs[i] != it.seq[i]) same = 0;
                    check("guess_seq", int'(same), 1);
                end
            end
            obs.delete();
        end else if (!busy) begin
            obs.delete();
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input int t, input int f, input bit mid_start);
        item_t it;
        int    q[$];
        target = 4'(t);
        fault  = f;
        if (f == 2) ref_seq(16, q);
        else        ref_seq(t, q);
        it.seq        = q;
        it.chk_seq    = (f != 1);
        it.exp_len    = (f == 1) ? 2 : q.size();
        it.exp_found  = (f == 0);
        it.exp_err    = (f != 0);
        it.exp_result = 4'(t);
        it.start_cyc  = cyc;
        sb.push_back(it);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (mid_start) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        fault = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; target = '0; fault = 0; cyc = 0; cmp_n = 0;
        repeat (2) @(negedge clk);
        check("rst_guess", int'(guess), 0);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'({busy, done, found, err}), 0);
        rst = 1'b0;
        @(negedge clk);

        run(8, 0, 0);
        run(5, 0, 0);
        run(0, 0, 0);
        run(15, 0, 0);
        for (int t = 0; t < 16; t++) run(t, 0, 0);

        run(3, 1, 0);
        run(7, 2, 0);

        run(5, 0, 1);

        target = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_guess", int'(guess), 0);
        check("abort_result", int'(result), 0);
        check("abort_flags", int'({busy, done, found, err}), 0);
        repeat (6) @(negedge clk);

        run(9, 0, 0);
        for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 15)), 0, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
